// File: rtl/vram_arbiter.sv
// Video RAM arbiter: shares one synchronous RAM between a display fetch port
// and a CPU port. Each access takes three edges (grant, access, capture).
// The display normally has priority, but a starvation counter guarantees the
// CPU a slot after CPU_MAXWAIT consecutive display grants while it waits.
module vram_arbiter #(
   parameter int AW          = 16,
   parameter int DW          = 8,
   parameter int CPU_MAXWAIT = 4
) (
   input  logic          clock,
   input  logic          reset_n,
   input  logic          dreq,
   input  logic [AW-1:0] daddr,
   output logic          dack,
   output logic [DW-1:0] ddata,
   input  logic          creq,
   input  logic          cwe,
   input  logic [AW-1:0] caddr,
   input  logic [DW-1:0] cwdata,
   output logic          cready,
   output logic [DW-1:0] crdata,
   output logic [AW-1:0] maddr,
   output logic [DW-1:0] mwdata,
   output logic          mwe,
   input  logic [DW-1:0] mrdata
);

   typedef enum logic [1:0] {
      IDLE,
      ACCESS,
      CAPTURE
   } state_t;

   localparam logic [3:0] MAXWAIT = 4'(CPU_MAXWAIT);

   state_t     state;
   logic       owner_cpu;
   logic       owner_write;
   logic [3:0] wait_cnt;
   logic       grant_cpu;
   logic       grant_disp;

   // Priority decision: the CPU wins only when the display is idle or the CPU has waited long enough
   always_comb begin
      grant_cpu  = creq && (!dreq || (wait_cnt == MAXWAIT));
      grant_disp = dreq && !grant_cpu;
   end

   // Access sequencer: launch the RAM cycle, drop write enable, then capture data and acknowledge the owner
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state       <= IDLE;
         owner_cpu   <= 1'b0;
         owner_write <= 1'b0;
         wait_cnt    <= 4'd0;
         maddr       <= '0;
         mwdata      <= '0;
         mwe         <= 1'b0;
         dack        <= 1'b0;
         cready      <= 1'b0;
         ddata       <= '0;
         crdata      <= '0;
      end else begin
         dack   <= 1'b0;
         cready <= 1'b0;
         case (state)
            IDLE: begin
               mwe <= 1'b0;
               if (grant_cpu) begin
                  maddr       <= caddr;
                  mwdata      <= cwdata;
                  mwe         <= cwe;
                  owner_cpu   <= 1'b1;
                  owner_write <= cwe;
                  wait_cnt    <= 4'd0;
                  state       <= ACCESS;
               end else if (grant_disp) begin
                  maddr       <= daddr;
                  owner_cpu   <= 1'b0;
                  owner_write <= 1'b0;
                  if (creq) begin
                     wait_cnt <= (wait_cnt == MAXWAIT) ? MAXWAIT : wait_cnt + 4'd1;
                  end else begin
                     wait_cnt <= 4'd0;
                  end
                  state <= ACCESS;
               end else if (!creq) begin
                  wait_cnt <= 4'd0;
               end
            end
            ACCESS: begin
               mwe   <= 1'b0;
               state <= CAPTURE;
            end
            CAPTURE: begin
               if (owner_cpu) begin
                  cready <= 1'b1;
                  if (!owner_write) begin
                     crdata <= mrdata;
                  end
               end else begin
                  dack  <= 1'b1;
                  ddata <= mrdata;
               end
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule
